hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core; sits beside the forwarding logic in the ID stage.
- Sequences three hazard types:
  - load-use stalls, which forwarding cannot cover;
  - taken-branch flushes resolved in EX;
  - multi-cycle MULT/DIV occupancy of EX, which freezes the front of the pipe.
- Drives PC / IF-ID write enables, the IF/ID and ID/EX flush (bubble) controls, and an EX hold. Keeps a saturating stall-cycle counter for performance reporting.

---
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / MULT-DIV hazard sequencer for the ID stage; controls are Mealy (same cycle).
// Stalls hold PC and IF/ID, bubbles go into ID/EX, EX is frozen for MDU_LAT cycles per MULT/DIV.
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_mdu_start,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             ex_hold,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  // The start cycle in RUN and the final cycle at mdu_cnt==0 both count toward MDU_LAT.
  localparam logic [7:0]       MDU_INIT = 8'(MDU_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t     state, state_nxt;
  logic [7:0] mdu_cnt, mdu_cnt_nxt;
  logic       done_q, done_nxt;
  logic       load_use;

  assign load_use = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    ex_hold     = 1'b0;
    mdu_busy    = 1'b0;
    state_nxt   = state;
    mdu_cnt_nxt = mdu_cnt;
    done_nxt    = 1'b0;

    case (state)
      RUN: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (idex_mdu_start && !done_q) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          ex_hold     = 1'b1;
          mdu_busy    = 1'b1;
          state_nxt   = MDU_WAIT;
          mdu_cnt_nxt = MDU_INIT;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end

      MDU_WAIT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ex_hold    = 1'b1;
        mdu_busy   = 1'b1;
        // done_q masks the still-asserted start for one cycle while the MULT/DIV leaves ID/EX.
        if (mdu_cnt == 8'd0) begin
          state_nxt = RUN;
          done_nxt  = 1'b1;
        end else begin
          mdu_cnt_nxt = mdu_cnt - 8'd1;
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      mdu_cnt <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
      done_q  <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_write && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Two hazard_ctrl instances (MDU_LAT=4/CNT_W=16 and MDU_LAT=3/CNT_W=3) against a cycle-level reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       idex_memread;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       ifid_uses_rt, idex_mdu_start, branch_taken;

  logic        pc_write_a, ifid_write_a, ifid_flush_a, idex_flush_a, ex_hold_a, mdu_busy_a;
  logic [15:0] stall_cnt_a;
  logic        pc_write_b, ifid_write_b, ifid_flush_b, idex_flush_b, ex_hold_b, mdu_busy_b;
  logic [2:0]  stall_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: remaining MDU stall cycles, "MDU just finished" flag, and an unbounded stall tally.
  int       lat[2]       = '{4, 3};
  int       sat[2]       = '{65535, 7};
  int       busy_left[2];
  bit       just_done[2];
  int       stalls[2];
  int       nxt_left[2];
  bit       nxt_done[2];
  logic [5:0] exp_ctl[2];

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_mdu_start(idex_mdu_start), .branch_taken(branch_taken),
    .pc_write(pc_write_a), .ifid_write(ifid_write_a), .ifid_flush(ifid_flush_a),
    .idex_flush(idex_flush_a), .ex_hold(ex_hold_a), .mdu_busy(mdu_busy_a),
    .stall_cnt(stall_cnt_a)
  );

  hazard_ctrl #(.MDU_LAT(3), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_mdu_start(idex_mdu_start), .branch_taken(branch_taken),
    .pc_write(pc_write_b), .ifid_write(ifid_write_b), .ifid_flush(ifid_flush_b),
    .idex_flush(idex_flush_b), .ex_hold(ex_hold_b), .mdu_busy(mdu_busy_b),
    .stall_cnt(stall_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctl_a();
    return {pc_write_a, ifid_write_a, ifid_flush_a, idex_flush_a, ex_hold_a, mdu_busy_a};
  endfunction

  function automatic logic [5:0] ctl_b();
    return {pc_write_b, ifid_write_b, ifid_flush_b, idex_flush_b, ex_hold_b, mdu_busy_b};
  endfunction

  task automatic drive(input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic ms, input logic br);
    idex_memread   = mr;
    idex_rt        = irt;
    ifid_rs        = rs;
    ifid_rt        = rt;
    ifid_uses_rt   = urt;
    idex_mdu_start = ms;
    branch_taken   = br;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      busy_left[i] = 0;
      just_done[i] = 1'b0;
      stalls[i]    = 0;
    end
  endtask

  // Control vector order: {pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, mdu_busy}
  task automatic model_eval(input int i);
    bit lu;
    lu = idex_memread && (idex_rt != 0) &&
         ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    nxt_left[i] = 0;
    nxt_done[i] = 1'b0;
    if (busy_left[i] > 0) begin
      exp_ctl[i]  = 6'b000011;
      nxt_left[i] = busy_left[i] - 1;
      nxt_done[i] = (busy_left[i] == 1);
    end else if (branch_taken) begin
      exp_ctl[i] = 6'b111100;
    end else if (idex_mdu_start && !just_done[i]) begin
      exp_ctl[i]  = 6'b000011;
      nxt_left[i] = lat[i] - 1;
    end else if (lu) begin
      exp_ctl[i] = 6'b000100;
    end else begin
      exp_ctl[i] = 6'b110000;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval(0);
    model_eval(1);
    check("ctl_a", 32'(ctl_a()), 32'(exp_ctl[0]));
    check("ctl_b", 32'(ctl_b()), 32'(exp_ctl[1]));
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!exp_ctl[i][5]) stalls[i] = (stalls[i] + 1 > sat[i]) ? sat[i] : stalls[i] + 1;
      busy_left[i] = nxt_left[i];
      just_done[i] = nxt_done[i];
    end
    check("cnt_a", 32'(stall_cnt_a), 32'(stalls[0]));
    check("cnt_b", 32'(stall_cnt_b), 32'(stalls[1]));
  endtask

  // Asserted away from the clock edge and held through one edge.
  task automatic do_reset();
    #2;
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_ctl_a", 32'(ctl_a()), 32'(6'b110000));
    check("rst_ctl_b", 32'(ctl_b()), 32'(6'b110000));
    check("rst_cnt_a", 32'(stall_cnt_a), 32'd0);
    check("rst_cnt_b", 32'(stall_cnt_b), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check("init_ctl_a", 32'(ctl_a()), 32'(6'b110000));
    check("init_cnt_a", 32'(stall_cnt_a), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    cycle();

    // Single load-use bubble, then no re-stall
    drive(1, 8, 8, 0, 0, 0, 0);
    cycle();
    drive(0, 8, 8, 0, 0, 0, 0);
    cycle();
    cycle();
    check("lu_cnt_a", 32'(stall_cnt_a), 32'd1);

    // No hazard: rt==0, or rt match without use
    drive(1, 0, 0, 0, 1, 0, 0);
    cycle();
    drive(1, 8, 3, 8, 0, 0, 0);
    cycle();
    check("lu_none_cnt_a", 32'(stall_cnt_a), 32'd1);

    // Branch beats load-use and MDU start
    drive(1, 8, 8, 8, 1, 1, 1);
    cycle();
    check("br_cnt_a", 32'(stall_cnt_a), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // MULT/DIV held high; hazards toggled during the stall
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive((k >= 1 && k <= 3), 8, 8, 0, 0, 1, (k == 1 || k == 3));
      if (k == 4) check("mdu_cnt_mid_a", 32'(stall_cnt_a), 32'd4);
      cycle();
    end
    check("mdu_done_ctl_a", 32'(exp_ctl[0]), 32'(6'b110000));
    check("mdu_cnt_a", 32'(stall_cnt_a), 32'd4);
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Reset in the second MDU cycle, then a full stall again
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0);
    cycle();
    @(negedge clk);
    do_reset();
    check("rst_mid_busy_a", 32'(mdu_busy_a), 32'd0);
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) cycle();
    check("remdu_cnt_a", 32'(stall_cnt_a), 32'd4);
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Saturation on the 3-bit counter
    do_reset();
    drive(1, 5, 7, 5, 1, 0, 0);
    for (int k = 0; k < 10; k++) cycle();
    check("sat_b", 32'(stall_cnt_b), 32'd7);
    check("nosat_a", 32'(stall_cnt_a), 32'd10);
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end
      drive(1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 6) == 0));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
